led_cube_scan_monitor: RTL and testbench

//   Receive-side monitor for the 3x3x3 LED cube drive interface. Samples the

---
 rtl/led_cube_scan_if.sv | 29 ++
 rtl/led_cube_scan_monitor.sv | 181 ++++++++++++++++++
 tb/tb_led_cube_scan_monitor.sv | 223 ++++++++++++++++++++++
 3 files changed

// File: rtl/led_cube_scan_if.sv
// Cube drive nets as seen by the scan monitor, plus the monitor's reporting outputs.
// master = whoever drives the cube lines (driver/bench), slave = the monitor.
interface led_cube_scan_if #(
  parameter int CNT_W = 8
);
  logic [2:0]       vert_n;
  logic [8:0]       rows;
  logic             clr_err;
  logic [26:0]      frame;
  logic             frame_valid;
  logic [CNT_W-1:0] frame_count;
  logic [1:0]       plane_idx;
  logic             test_active;
  logic             scan_err;
  logic [1:0]       err_code;
  logic [1:0]       state_dbg;

  modport master (
    output vert_n, rows, clr_err,
    input  frame, frame_valid, frame_count, plane_idx,
           test_active, scan_err, err_code, state_dbg
  );

  modport slave (
    input  vert_n, rows, clr_err,
    output frame, frame_valid, frame_count, plane_idx,
           test_active, scan_err, err_code, state_dbg
  );
endinterface

// File: rtl/led_cube_scan_monitor.sv
// Passive monitor of the 3x3x3 cube scan: checks plane0->1->2 ordering, rebuilds
// each full sweep into a 27-bit frame, and latches the first scan error seen.
module led_cube_scan_monitor #(
  parameter int CNT_W = 8
) (
  input  logic            clk_1Hz,
  input  logic            reset_n,
  led_cube_scan_if.slave  scan_if
);

  typedef enum logic [1:0] {
    SYNC = 2'd0,
    EXP0 = 2'd1,
    EXP1 = 2'd2,
    EXP2 = 2'd3
  } state_t;

  typedef enum logic [2:0] {
    SEL_P0,
    SEL_P1,
    SEL_P2,
    SEL_BLANK,
    SEL_ALL,
    SEL_ILL
  } sel_t;

  localparam logic [1:0] ERR_NONE  = 2'd0;
  localparam logic [1:0] ERR_ORDER = 2'd1;
  localparam logic [1:0] ERR_ILL   = 2'd2;
  localparam logic [1:0] ERR_GHOST = 2'd3;

  state_t           state_q, state_d;
  logic [17:0]      shadow_q, shadow_d;
  logic [26:0]      frame_q, frame_d;
  logic             frame_vld_q, frame_vld_d;
  logic [CNT_W-1:0] count_q, count_d;
  logic [1:0]       plane_q, plane_d;
  logic             test_q, test_d;
  logic             err_q, err_d;
  logic [1:0]       code_q, code_d;

  sel_t       sel;
  logic       err_hit;
  logic [1:0] err_new;

  always_comb begin
    sel = SEL_ILL;
    unique case (scan_if.vert_n)
      3'b110:  sel = SEL_P0;
      3'b101:  sel = SEL_P1;
      3'b011:  sel = SEL_P2;
      3'b111:  sel = SEL_BLANK;
      3'b000:  sel = SEL_ALL;
      default: sel = SEL_ILL;
    endcase
  end

  always_comb begin
    state_d     = state_q;
    shadow_d    = shadow_q;
    frame_d     = frame_q;
    frame_vld_d = 1'b0;
    count_d     = count_q;
    err_hit     = 1'b0;
    err_new     = ERR_NONE;

    unique case (sel)
      SEL_ILL: begin
        err_hit = 1'b1;
        err_new = ERR_ILL;
        state_d = SYNC;
      end
      SEL_BLANK: begin
        state_d = SYNC;
        // Rows lit while no plane is selected means a leaky driver line.
        if (scan_if.rows != 9'd0) begin
          err_hit = 1'b1;
          err_new = ERR_GHOST;
        end
      end
      SEL_ALL: state_d = SYNC;
      default: begin
        unique case (state_q)
          SYNC: begin
            // Planes 1/2 before lock are simply ignored until plane0 appears.
            if (sel == SEL_P0) begin
              shadow_d[8:0] = scan_if.rows;
              state_d       = EXP1;
            end
          end
          EXP0: begin
            if (sel == SEL_P0) begin
              shadow_d[8:0] = scan_if.rows;
              state_d       = EXP1;
            end else begin
              err_hit = 1'b1;
              err_new = ERR_ORDER;
              state_d = SYNC;
            end
          end
          EXP1: begin
            if (sel == SEL_P1) begin
              shadow_d[17:9] = scan_if.rows;
              state_d        = EXP2;
            end else begin
              err_hit = 1'b1;
              err_new = ERR_ORDER;
              state_d = SYNC;
            end
          end
          EXP2: begin
            if (sel == SEL_P2) begin
              frame_d     = {scan_if.rows, shadow_q};
              frame_vld_d = 1'b1;
              count_d     = count_q + CNT_W'(1);
              state_d     = EXP0;
            end else begin
              err_hit = 1'b1;
              err_new = ERR_ORDER;
              state_d = SYNC;
            end
          end
          default: state_d = SYNC;
        endcase
      end
    endcase

    // First error is kept; a clear in the same cycle as a new error yields the new code.
    err_d  = err_q;
    code_d = code_q;
    if (err_hit) begin
      err_d = 1'b1;
      if (!err_q || scan_if.clr_err) code_d = err_new;
    end else if (scan_if.clr_err) begin
      err_d  = 1'b0;
      code_d = ERR_NONE;
    end

    unique case (sel)
      SEL_P0:  plane_d = 2'd0;
      SEL_P1:  plane_d = 2'd1;
      SEL_P2:  plane_d = 2'd2;
      default: plane_d = 2'd3;
    endcase
    test_d = (scan_if.vert_n == 3'b000) && (scan_if.rows == 9'h1FF);
  end

  always_ff @(posedge clk_1Hz or negedge reset_n) begin
    if (!reset_n) begin
      state_q     <= SYNC;
      shadow_q    <= '0;
      frame_q     <= '0;
      frame_vld_q <= 1'b0;
      count_q     <= '0;
      plane_q     <= 2'd3;
      test_q      <= 1'b0;
      err_q       <= 1'b0;
      code_q      <= ERR_NONE;
    end else begin
      state_q     <= state_d;
      shadow_q    <= shadow_d;
      frame_q     <= frame_d;
      frame_vld_q <= frame_vld_d;
      count_q     <= count_d;
      plane_q     <= plane_d;
      test_q      <= test_d;
      err_q       <= err_d;
      code_q      <= code_d;
    end
  end

  assign scan_if.frame       = frame_q;
  assign scan_if.frame_valid = frame_vld_q;
  assign scan_if.frame_count = count_q;
  assign scan_if.plane_idx   = plane_q;
  assign scan_if.test_active = test_q;
  assign scan_if.scan_err    = err_q;
  assign scan_if.err_code    = code_q;
  assign scan_if.state_dbg   = state_q;

endmodule

// File: tb/tb_led_cube_scan_monitor.sv
// Bench for led_cube_scan_monitor: directed vector table, randomized run against a
// sweep-level model, counter wrap, and async reset / clear-collision sequences.
module tb_led_cube_scan_monitor;
  localparam int CNT_W = 8;

  logic clk_1Hz = 1'b0;
  logic reset_n = 1'b0;
  always #5 clk_1Hz = ~clk_1Hz;

  led_cube_scan_if #(.CNT_W(CNT_W)) scan ();

  led_cube_scan_monitor #(.CNT_W(CNT_W)) dut (
    .clk_1Hz (clk_1Hz),
    .reset_n (reset_n),
    .scan_if (scan.slave)
  );

  int checks   = 0;
  int failures = 0;

  // Reference model: expected plane as an integer (-1 = not locked) and the rows per plane.
  int         m_exp;
  logic [8:0] m_part [3];
  logic [26:0] m_frame;
  logic       m_valid;
  int         m_count;
  int         m_pidx;
  logic       m_test;
  logic       m_err;
  int         m_code;

  task automatic chk(input string name, input logic [31:0] act, input logic [31:0] exp);
    checks++;
    if (act !== exp) begin
      failures++;
      $display("FAIL %s: got %0h expected %0h at %0t", name, act, exp, $time);
    end
  endtask

  task automatic model_reset();
    m_exp = -1; m_frame = '0; m_valid = 1'b0; m_count = 0; m_pidx = 3;
    m_test = 1'b0; m_err = 1'b0; m_code = 0;
    for (int p = 0; p < 3; p++) m_part[p] = '0;
  endtask

  task automatic model_step(input logic [2:0] v, input logic [8:0] r, input logic c);
    int zeros, plane, e;
    zeros = 0; plane = 3; e = 0;
    for (int b = 0; b < 3; b++) if (!v[b]) begin zeros++; plane = b; end
    m_valid = 1'b0;
    if (zeros == 2) begin
      e = 2; m_exp = -1; plane = 3;
    end else if (zeros == 0) begin
      if (r != 0) e = 3;
      m_exp = -1; plane = 3;
    end else if (zeros == 3) begin
      m_exp = -1; plane = 3;
    end else if (m_exp < 0) begin
      if (plane == 0) begin m_part[0] = r; m_exp = 1; end
    end else if (plane == m_exp) begin
      m_part[plane] = r;
      if (plane == 2) begin
        m_frame = {m_part[2], m_part[1], m_part[0]};
        m_valid = 1'b1;
        m_count = (m_count + 1) % (1 << CNT_W);
        m_exp = 0;
      end else m_exp = plane + 1;
    end else begin
      e = 1; m_exp = -1;
    end
    if (e != 0) begin
      if (!m_err || c) m_code = e;
      m_err = 1'b1;
    end else if (c) begin
      m_err = 1'b0; m_code = 0;
    end
    m_pidx = plane;
    m_test = (v == 3'b000) && (r == 9'h1FF);
  endtask

  task automatic cycle(input logic [2:0] v, input logic [8:0] r, input logic c);
    scan.vert_n = v; scan.rows = r; scan.clr_err = c;
    @(posedge clk_1Hz);
    model_step(v, r, c);
    #1;
  endtask

  task automatic compare_model(input string tag);
    chk({tag, ".frame"},  32'(scan.frame),       32'(m_frame));
    chk({tag, ".valid"},  32'(scan.frame_valid), 32'(m_valid));
    chk({tag, ".count"},  32'(scan.frame_count), 32'(m_count));
    chk({tag, ".pidx"},   32'(scan.plane_idx),   32'(m_pidx));
    chk({tag, ".test"},   32'(scan.test_active), 32'(m_test));
    chk({tag, ".err"},    32'(scan.scan_err),    32'(m_err));
    chk({tag, ".code"},   32'(scan.err_code),    32'(m_code));
    chk({tag, ".state"},  32'(scan.state_dbg),   32'(m_exp < 0 ? 0 : m_exp + 1));
  endtask

  task automatic check_reset_values(input string tag);
    chk({tag, ".frame"}, 32'(scan.frame),       32'd0);
    chk({tag, ".valid"}, 32'(scan.frame_valid), 32'd0);
    chk({tag, ".count"}, 32'(scan.frame_count), 32'd0);
    chk({tag, ".pidx"},  32'(scan.plane_idx),   32'd3);
    chk({tag, ".test"},  32'(scan.test_active), 32'd0);
    chk({tag, ".err"},   32'(scan.scan_err),    32'd0);
    chk({tag, ".code"},  32'(scan.err_code),    32'd0);
    chk({tag, ".state"}, 32'(scan.state_dbg),   32'd0);
  endtask

  typedef struct {
    logic [2:0]  vert_n;
    logic [8:0]  rows;
    logic        clr;
    logic [26:0] frame;
    logic        valid;
    logic [7:0]  count;
    logic [1:0]  pidx;
    logic        test;
    logic        err;
    logic [1:0]  code;
    logic [1:0]  state;
  } vec_t;

  vec_t vecs [15];
  int   pulses;
  int   cnt_start;
  logic [2:0] v;
  logic [8:0] r;

  initial begin
    //             vert    rows    clr  frame          vld cnt pidx test err code state
    vecs[0]  = '{3'b110, 9'h007, 1'b0, 27'h0,         0, 0, 0, 0, 0, 0, 2};
    vecs[1]  = '{3'b101, 9'h038, 1'b0, 27'h0,         0, 0, 1, 0, 0, 0, 3};
    vecs[2]  = '{3'b011, 9'h1C0, 1'b0, 27'h7007007,   1, 1, 2, 0, 0, 0, 1};
    vecs[3]  = '{3'b111, 9'h000, 1'b0, 27'h7007007,   0, 1, 3, 0, 0, 0, 0};
    vecs[4]  = '{3'b110, 9'h0AA, 1'b0, 27'h7007007,   0, 1, 0, 0, 0, 0, 2};
    vecs[5]  = '{3'b011, 9'h055, 1'b0, 27'h7007007,   0, 1, 2, 0, 1, 1, 0};
    vecs[6]  = '{3'b111, 9'h000, 1'b1, 27'h7007007,   0, 1, 3, 0, 0, 0, 0};
    vecs[7]  = '{3'b100, 9'h000, 1'b0, 27'h7007007,   0, 1, 3, 0, 1, 2, 0};
    vecs[8]  = '{3'b111, 9'h001, 1'b0, 27'h7007007,   0, 1, 3, 0, 1, 2, 0};
    vecs[9]  = '{3'b111, 9'h000, 1'b1, 27'h7007007,   0, 1, 3, 0, 0, 0, 0};
    vecs[10] = '{3'b000, 9'h1FF, 1'b0, 27'h7007007,   0, 1, 3, 1, 0, 0, 0};
    vecs[11] = '{3'b111, 9'h000, 1'b0, 27'h7007007,   0, 1, 3, 0, 0, 0, 0};
    vecs[12] = '{3'b110, 9'h1FF, 1'b0, 27'h7007007,   0, 1, 0, 0, 0, 0, 2};
    vecs[13] = '{3'b000, 9'h1FF, 1'b0, 27'h7007007,   0, 1, 3, 1, 0, 0, 0};
    vecs[14] = '{3'b000, 9'h0F0, 1'b0, 27'h7007007,   0, 1, 3, 0, 0, 0, 0};

    scan.vert_n = 3'b111; scan.rows = '0; scan.clr_err = 1'b0;
    model_reset();
    #12;
    check_reset_values("reset");
    @(negedge clk_1Hz);
    reset_n = 1'b1;

    for (int i = 0; i < 15; i++) begin
      cycle(vecs[i].vert_n, vecs[i].rows, vecs[i].clr);
      chk($sformatf("vec%0d.frame", i), 32'(scan.frame),       32'(vecs[i].frame));
      chk($sformatf("vec%0d.valid", i), 32'(scan.frame_valid), 32'(vecs[i].valid));
      chk($sformatf("vec%0d.count", i), 32'(scan.frame_count), 32'(vecs[i].count));
      chk($sformatf("vec%0d.pidx", i),  32'(scan.plane_idx),   32'(vecs[i].pidx));
      chk($sformatf("vec%0d.test", i),  32'(scan.test_active), 32'(vecs[i].test));
      chk($sformatf("vec%0d.err", i),   32'(scan.scan_err),    32'(vecs[i].err));
      chk($sformatf("vec%0d.code", i),  32'(scan.err_code),    32'(vecs[i].code));
      chk($sformatf("vec%0d.state", i), 32'(scan.state_dbg),   32'(vecs[i].state));
    end

    // Randomized traffic, mostly following the sweep so frames complete regularly.
    for (int i = 0; i < 400; i++) begin
      if ($urandom_range(0, 9) < 7)
        v = 3'b111 ^ (3'b001 << (m_exp < 0 ? 0 : m_exp));
      else
        v = 3'($urandom_range(0, 7));
      r = 9'($urandom_range(0, 511));
      if (v == 3'b111 && $urandom_range(0, 3) != 0) r = '0;
      cycle(v, r, $urandom_range(0, 9) == 0);
      compare_model($sformatf("rand%0d", i));
    end

    // Counter wrap: 256 clean sweeps must bring frame_count back to its start value.
    cycle(3'b111, 9'h000, 1'b1);
    compare_model("wrap_pre");
    cnt_start = m_count;
    pulses = 0;
    for (int s = 0; s < 256; s++) begin
      for (int p = 0; p < 3; p++) begin
        cycle(3'b111 ^ (3'b001 << p), 9'($urandom_range(0, 511)), 1'b0);
        if (scan.frame_valid) pulses++;
        if (p == 2) compare_model($sformatf("wrap%0d", s));
      end
    end
    chk("wrap_pulses", 32'(pulses), 32'd256);
    chk("wrap_count", 32'(scan.frame_count), 32'(cnt_start));
    chk("wrap_err", 32'(scan.scan_err), 32'd0);

    // Async reset while waiting for plane2; the following plane2 must not finish a frame.
    cycle(3'b110, 9'h111, 1'b0);
    cycle(3'b101, 9'h0C3, 1'b0);
    compare_model("pre_rst");
    #2 reset_n = 1'b0;
    #1 check_reset_values("midrst");
    model_reset();
    #2 reset_n = 1'b1;
    cycle(3'b011, 9'h1C0, 1'b0);
    chk("post_rst.valid", 32'(scan.frame_valid), 32'd0);
    chk("post_rst.state", 32'(scan.state_dbg), 32'd0);
    compare_model("post_rst");

    // Clear colliding with a new error: flag stays, code becomes the new one.
    cycle(3'b110, 9'h001, 1'b0);
    cycle(3'b011, 9'h002, 1'b0);
    chk("order.code", 32'(scan.err_code), 32'd1);
    cycle(3'b001, 9'h000, 1'b1);
    chk("clr_collide.err", 32'(scan.scan_err), 32'd1);
    chk("clr_collide.code", 32'(scan.err_code), 32'd2);
    compare_model("clr_collide");
    cycle(3'b111, 9'h000, 1'b1);
    compare_model("clr_after");

    $display("TB_RESULT checks=%0d failures=%0d", checks, failures);
    $finish;
  end

endmodule
